// File: rtl/ras_pkg.sv
// Shared defaults and derived widths for the return address stack.
// Pointer is log2(DEPTH) bits; count needs one more bit to represent a full stack.
package ras_pkg;
    localparam int RAS_DEPTH = 8;
    localparam int RAS_AW    = 32;
    localparam int RAS_PW    = $clog2(RAS_DEPTH);
    localparam int RAS_CW    = RAS_PW + 1;
endpackage

// File: rtl/ras_storage.sv
// Entry array for the return address stack: one write port, one combinational read port.
// Latency: write lands at the clock edge, read is same-cycle.
// Backpressure: none; the caller qualifies the write enable.
module ras_storage
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = RAS_AW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [AW-1:0]            wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [AW-1:0]            rd_data
);
    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/return_addr_stack.sv
// Fetch-stage return address predictor (circular LIFO); RAS_CHECKPOINT_EN adds snapshot/restore.
// Latency: prediction is combinational in the cycle of the pop; state updates at the edge.
// Backpressure: iStall freezes all state and suppresses the prediction.
module return_addr_stack
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = RAS_AW
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    input  logic                       iPushCmd,
    input  logic [AW-1:0]              iPushAddr,
    input  logic                       iPopCmd,
    input  logic                       iStall,
    input  logic                       iFlush,
    input  logic                       iCheckpoint,
    input  logic                       iBranchMissCmd,
    output logic [AW-1:0]              oRetAddr,
    output logic                       oRetCmd,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic                       oEmpty,
    output logic                       oFull,
    output logic                       oOverflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          empty;
    logic          full;
    logic          restore;
    logic          act;
    logic          do_push;
    logic          do_pop;
    logic          replace;
    logic [PW-1:0] wr_addr;
    logic [AW-1:0] top;

`ifdef RAS_CHECKPOINT_EN
    logic [PW-1:0] snap_ptr;
    logic [CW-1:0] snap_cnt;

    assign restore = iBranchMissCmd;

    // Restore outranks capture, so a simultaneous checkpoint leaves the snapshot alone.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            snap_ptr <= '0;
            snap_cnt <= '0;
        end else if (iCheckpoint && !iFlush && !iBranchMissCmd && !iStall) begin
            snap_ptr <= ptr;
            snap_cnt <= cnt;
        end
    end
`else
    logic unused_ckpt;

    assign restore     = 1'b0;
    assign unused_ckpt = iCheckpoint ^ iBranchMissCmd;
`endif

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign act     = !iFlush && !restore && !iStall;
    assign do_push = act && iPushCmd;
    assign do_pop  = act && iPopCmd && !empty;
    // Push+pop on a non-empty stack swaps the top entry in place.
    assign replace = do_push && do_pop;
    assign wr_addr = replace ? ptr : ptr + PW'(1);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ptr <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (iFlush) begin
                ptr <= '0;
                cnt <= '0;
`ifdef RAS_CHECKPOINT_EN
            end else if (restore) begin
                ptr <= snap_ptr;
                cnt <= snap_cnt;
`endif
            end else if (do_push && !do_pop) begin
                ptr <= ptr + PW'(1);
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (do_pop && !do_push) begin
                ptr <= ptr - PW'(1);
                cnt <= cnt - CW'(1);
            end
        end
    end

    ras_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk     (iClk),
        .rst_n   (iRst_n),
        .wr_en   (do_push),
        .wr_addr (wr_addr),
        .wr_data (iPushAddr),
        .rd_addr (ptr),
        .rd_data (top)
    );

    assign oRetAddr  = empty ? '0 : top;
    assign oRetCmd   = iPopCmd && !empty && !iStall && !iFlush;
    assign oCount    = cnt;
    assign oEmpty    = empty;
    assign oFull     = full;
    assign oOverflow = ovf;
endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack with a queue-based reference of stack contents.
module tb_return_addr_stack;
    localparam int DEPTH = 8;
    localparam int AW    = 32;

    logic          iClk = 1'b0;
    logic          iRst_n;
    logic          iPushCmd;
    logic [AW-1:0] iPushAddr;
    logic          iPopCmd;
    logic          iStall;
    logic          iFlush;
    logic          iCheckpoint;
    logic          iBranchMissCmd;
    logic [AW-1:0] oRetAddr;
    logic          oRetCmd;
    logic [3:0]    oCount;
    logic          oEmpty;
    logic          oFull;
    logic          oOverflow;

    int passed = 0;
    int total  = 0;
    logic [AW-1:0] model[$];
    logic [AW-1:0] exp_addr;

    always #5 iClk = ~iClk;

    return_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .iClk           (iClk),
        .iRst_n         (iRst_n),
        .iPushCmd       (iPushCmd),
        .iPushAddr      (iPushAddr),
        .iPopCmd        (iPopCmd),
        .iStall         (iStall),
        .iFlush         (iFlush),
        .iCheckpoint    (iCheckpoint),
        .iBranchMissCmd (iBranchMissCmd),
        .oRetAddr       (oRetAddr),
        .oRetCmd        (oRetCmd),
        .oCount         (oCount),
        .oEmpty         (oEmpty),
        .oFull          (oFull),
        .oOverflow      (oOverflow)
    );

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        iPushCmd = 0; iPushAddr = '0; iPopCmd = 0; iStall = 0;
        iFlush = 0; iCheckpoint = 0; iBranchMissCmd = 0;
    endtask

    // Advance one edge, settle, and return inputs to idle.
    task automatic tick();
        @(posedge iClk);
        #1;
        idle_inputs();
    endtask

    task automatic push(input logic [AW-1:0] a);
        iPushCmd = 1; iPushAddr = a;
        model.push_back(a);
        if (model.size() > DEPTH) void'(model.pop_front());
        tick();
    endtask

    task automatic pop_expect(input string tag);
        iPopCmd = 1;
        #2;
        exp_addr = model.pop_back();
        check({tag, "_cmd"}, AW'(oRetCmd), 1);
        check({tag, "_addr"}, oRetAddr, exp_addr);
        tick();
    endtask

    task automatic pop_empty(input string tag);
        iPopCmd = 1;
        #2;
        check({tag, "_cmd"}, AW'(oRetCmd), 0);
        check({tag, "_addr"}, oRetAddr, 0);
        tick();
        check({tag, "_cnt"}, AW'(oCount), 0);
    endtask

    initial begin
        idle_inputs();
        iRst_n = 0;
        #12;
        check("rst_cnt", AW'(oCount), 0);
        check("rst_empty", AW'(oEmpty), 1);
        check("rst_full", AW'(oFull), 0);
        check("rst_ovf", AW'(oOverflow), 0);
        check("rst_addr", AW'(oRetAddr), 0);
        iRst_n = 1;
        tick();

        // Basic LIFO order
        push(32'h100); push(32'h200); push(32'h300);
        check("cnt3", AW'(oCount), 3);
        pop_expect("pop300");
        pop_expect("pop200");
        pop_expect("pop100");
        check("empty_after", AW'(oEmpty), 1);
        check("cnt0_after", AW'(oCount), 0);
        pop_empty("underflow");

        // Overflow: 9 pushes into an 8-deep stack
        for (int i = 1; i <= 9; i++) begin
            push(AW'(i * 16));
            if (i == 8) begin
                check("full8", AW'(oFull), 1);
                check("no_ovf8", AW'(oOverflow), 0);
            end
        end
        check("ovf_pulse", AW'(oOverflow), 1);
        check("ovf_cnt", AW'(oCount), 8);
        tick();
        check("ovf_clear", AW'(oOverflow), 0);
        for (int i = 0; i < 8; i++) pop_expect("ovf_pop");
        pop_empty("ovf_under");

        // Simultaneous push and pop replaces the top
        push(32'h400);
        iPushCmd = 1; iPushAddr = 32'h500; iPopCmd = 1;
        #2;
        exp_addr = model.pop_back();
        check("swap_cmd", AW'(oRetCmd), 1);
        check("swap_addr", oRetAddr, exp_addr);
        model.push_back(32'h500);
        tick();
        check("swap_cnt", AW'(oCount), 1);
        pop_expect("swap_pop");

        // Push+pop on empty acts as a plain push
        iPushCmd = 1; iPushAddr = 32'h600; iPopCmd = 1;
        #2;
        check("swap_empty_cmd", AW'(oRetCmd), 0);
        model.push_back(32'h600);
        tick();
        check("swap_empty_cnt", AW'(oCount), 1);

        // Stall freezes everything
        iStall = 1; iPushCmd = 1; iPushAddr = 32'h40;
        tick();
        check("stall_push_cnt", AW'(oCount), 1);
        iStall = 1; iPopCmd = 1;
        #2;
        check("stall_pop_cmd", AW'(oRetCmd), 0);
        tick();
        check("stall_pop_cnt", AW'(oCount), 1);
        pop_expect("post_stall");

        // Flush empties the stack
        push(32'h700); push(32'h800); push(32'h900);
        iFlush = 1; iPopCmd = 1;
        #2;
        check("flush_cmd", AW'(oRetCmd), 0);
        tick();
        model.delete();
        check("flush_cnt", AW'(oCount), 0);
        check("flush_empty", AW'(oEmpty), 1);

`ifdef RAS_CHECKPOINT_EN
        push(32'hA0);
        iCheckpoint = 1;
        tick();
        push(32'hB0);
        pop_expect("ck_popB0");
        pop_expect("ck_popA0");
        iBranchMissCmd = 1;
        tick();
        check("ck_cnt", AW'(oCount), 1);
        check("ck_addr", oRetAddr, 32'hA0);
        model.push_back(32'hA0);
`endif

        // Asynchronous reset mid-operation
        push(32'hC0); push(32'hD0);
        #2;
        iRst_n = 0;
        iPopCmd = 1;
        #1;
        check("arst_cnt", AW'(oCount), 0);
        check("arst_empty", AW'(oEmpty), 1);
        check("arst_cmd", AW'(oRetCmd), 0);
        check("arst_addr", oRetAddr, 0);
        check("arst_ovf", AW'(oOverflow), 0);
        model.delete();
        iPopCmd = 0;
        #3;
        iRst_n = 1;
        tick();
        pop_empty("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
